// File: rtl/demux_rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : demux_rr_dispatch
// Description : Round-robin dispatcher for a 1-to-8 demux. Takes a single
//               valid/ready stream and hands each word to one enabled output
//               channel in strict rotation, through one registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_dispatch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   en_mask,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [2:0]   sel,
  output logic [15:0]  xfer_cnt
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] ptr;
  logic [2:0] pick_idx;
  logic [2:0] idx;
  logic       out_transfer;
  logic       in_accept;

  // Handshakes: only the owning channel's ready matters; a stalled owner
  // blocks the stream rather than being skipped.
  always_comb begin
    out_transfer = out_valid[sel] & out_ready[sel];
    in_ready     = (en_mask != 8'd0) && ((state == EMPTY) || out_transfer);
    in_accept    = in_valid & in_ready;
  end

  // Rotating search starting at ptr; walking offsets from high to low lets
  // the smallest offset with an enabled channel win without an early exit.
  always_comb begin
    pick_idx = ptr;
    idx      = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (en_mask[idx]) begin
        pick_idx = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a new word keeps us FULL, a lone drain empties us.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (in_accept) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_transfer && !in_accept) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Output stage: load on accept, clear valid on a lone drain, count drains.
  // out_data and sel intentionally keep their last values when emptying.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 3'd0;
      sel       <= 3'd0;
      out_valid <= 8'd0;
      out_data  <= '0;
      xfer_cnt  <= 16'd0;
    end else begin
      if (in_accept) begin
        out_data  <= in_data;
        sel       <= pick_idx;
        out_valid <= 8'b1 << pick_idx;
        ptr       <= pick_idx + 3'd1;
      end else if (out_transfer) begin
        out_valid <= 8'd0;
      end
      if (out_transfer) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_rr_dispatch
// Description : Self-checking bench for demux_rr_dispatch with a behavioural
//               single-slot reference model and per-scenario tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_dispatch;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   en_mask = 8'd0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready = 8'd0;
  logic [2:0]   sel;
  logic [15:0]  xfer_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: one held word, its channel, rotation start, counter.
  bit           m_full;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_ptr;
  int           m_cnt;
  int           dq_ch[$];
  logic [W-1:0] dq_data[$];

  demux_rr_dispatch #(.W(W)) dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pick(int p, logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      if (m[(p + i) % 8]) return (p + i) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_valid();
    return m_full ? 8'(1 << m_ch) : 8'd0;
  endfunction

  function automatic bit m_ready();
    return (en_mask != 0) && (!m_full || out_ready[m_ch]);
  endfunction

  // Advance one clock edge, updating the model from the inputs seen there.
  task automatic cycle();
    bit xfer;
    bit acc;
    int k;
    xfer = m_full && out_ready[m_ch];
    acc  = in_valid && (en_mask != 0) && (!m_full || xfer);
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (xfer) begin
        m_cnt = (m_cnt + 1) % 65536;
        dq_ch.push_back(m_ch);
        dq_data.push_back(m_data);
      end
      if (acc) begin
        k = pick(m_ptr, en_mask);
        m_ch = k; m_data = in_data; m_ptr = (k + 1) % 8; m_full = 1;
      end else if (xfer) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    dq_ch.delete();
    dq_data.delete();
  endtask

  task automatic test_reset();
    en_mask = 8'hFF; out_ready = 8'hFF; in_valid = 0;
    do_reset();
    checks++;
    if (out_valid !== 8'd0 || sel !== 3'd0 || out_data !== '0 || xfer_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%h sel=%0d data=%h cnt=%0d, required 0/0/0/0",
               out_valid, sel, out_data, xfer_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_mask_ff: got %b required 1", in_ready);
    end
    en_mask = 8'h00; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_mask_0: got %b required 0", in_ready);
    end
  endtask

  task automatic test_rotation();
    en_mask = 8'hFF; out_ready = 8'hFF;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_data = 8'(8'h10 + i); #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rot_ready[%0d]: got %b required 1", i, in_ready);
      end
      cycle();
      checks++;
      if (out_valid !== 8'(1 << (i % 8)) || out_data !== 8'(8'h10 + i) || sel !== 3'(i % 8)) begin
        failures++;
        $display("FAIL rot_word[%0d]: valid=%h data=%h sel=%0d required %h/%h/%0d",
                 i, out_valid, out_data, sel, 8'(1 << (i % 8)), 8'(8'h10 + i), i % 8);
      end
      if (i == 8) begin
        checks++;
        if (xfer_cnt !== 16'd8) begin
          failures++;
          $display("FAIL rot_cnt8: got %0d required 8", xfer_cnt);
        end
      end
    end
    in_valid = 0;
    cycle();
    checks++;
    if (xfer_cnt !== 16'd9 || out_valid !== 8'd0 || sel !== 3'd0) begin
      failures++;
      $display("FAIL rot_drain: cnt=%0d valid=%h sel=%0d required 9/00/0", xfer_cnt, out_valid, sel);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dq_ch.size() != 9 || dq_ch[i] != i % 8 || dq_data[i] !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL rot_delivery[%0d]: count=%0d, required ch %0d data %h",
                 i, dq_ch.size(), i % 8, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_sparse();
    int exp_ch[6] = '{0, 2, 5, 0, 2, 5};
    en_mask = 8'h25; out_ready = 8'hFF;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = 8'(8'hA + i);
      cycle();
      checks++;
      if (out_valid !== 8'(1 << exp_ch[i]) || out_data !== 8'(8'hA + i)) begin
        failures++;
        $display("FAIL sparse_word[%0d]: valid=%h data=%h required %h/%h",
                 i, out_valid, out_data, 8'(1 << exp_ch[i]), 8'(8'hA + i));
      end
    end
    in_valid = 0;
    cycle();
    checks++;
    if (out_valid !== 8'd0 || xfer_cnt !== 16'd6) begin
      failures++;
      $display("FAIL sparse_drain: valid=%h cnt=%0d required 00/6", out_valid, xfer_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dq_ch.size() != 6 || dq_ch[i] != exp_ch[i]) begin
        failures++;
        $display("FAIL sparse_delivery[%0d]: count=%0d required ch %0d", i, dq_ch.size(), exp_ch[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    en_mask = 8'hFF; out_ready = 8'hFD;
    do_reset();
    in_valid = 1; in_data = 8'h30; cycle();
    in_data = 8'h31; cycle();
    in_data = 8'h32;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready[%0d]: got %b required 0", i, in_ready);
      end
      cycle();
      checks++;
      if (out_valid !== 8'h02 || out_data !== 8'h31 || xfer_cnt !== 16'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%h data=%h cnt=%0d required 02/31/1",
                 i, out_valid, out_data, xfer_cnt);
      end
    end
    out_ready = 8'hFF; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b required 1", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 8'h04 || out_data !== 8'h32 || xfer_cnt !== 16'd2) begin
      failures++;
      $display("FAIL bp_release: valid=%h data=%h cnt=%0d required 04/32/2",
               out_valid, out_data, xfer_cnt);
    end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_mask_change();
    en_mask = 8'hFF; out_ready = 8'hF7;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 8'(8'h40 + i); cycle();
    end
    in_data = 8'h44; en_mask = 8'h01; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mask_stall_ready: got %b required 0", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 8'h08 || out_data !== 8'h43 || sel !== 3'd3) begin
      failures++;
      $display("FAIL mask_held: valid=%h data=%h sel=%0d required 08/43/3", out_valid, out_data, sel);
    end
    out_ready = 8'hFF;
    cycle();
    checks++;
    if (out_valid !== 8'h01 || out_data !== 8'h44 || xfer_cnt !== 16'd4) begin
      failures++;
      $display("FAIL mask_next_ch0: valid=%h data=%h cnt=%0d required 01/44/4",
               out_valid, out_data, xfer_cnt);
    end
    checks++;
    if (dq_ch.size() == 0 || dq_ch[$] != 3 || dq_data[$] !== 8'h43) begin
      failures++;
      $display("FAIL mask_delivery: count=%0d required last delivery ch 3 data 43", dq_ch.size());
    end
    en_mask = 8'h00; in_data = 8'h45; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mask_zero_ready: got %b required 0", in_ready);
    end
    cycle();
    cycle();
    checks++;
    if (out_valid !== 8'h00 || xfer_cnt !== 16'd5 || in_ready !== 1'b0 || out_data !== 8'h44) begin
      failures++;
      $display("FAIL mask_zero_drain: valid=%h cnt=%0d ready=%b data=%h required 00/5/0/44",
               out_valid, xfer_cnt, in_ready, out_data);
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 9))
        0:       en_mask = 8'h00;
        1, 2:    en_mask = 8'(1 << $urandom_range(0, 7));
        default: if ($urandom_range(0, 3) == 0) en_mask = 8'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rand_ready[%0d]: got %b required %b", n, in_ready, m_ready());
      end
      cycle();
      checks++;
      if (out_valid !== m_valid() || out_data !== m_data || sel !== 3'(m_ch) ||
          xfer_cnt !== 16'(m_cnt)) begin
        failures++; bad++;
        if (bad < 10)
          $display("FAIL rand_out[%0d]: valid=%h data=%h sel=%0d cnt=%0d required %h/%h/%0d/%0d",
                   n, out_valid, out_data, sel, xfer_cnt, m_valid(), m_data, m_ch, m_cnt);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_wrap_reset();
    int guard = 0;
    en_mask = 8'hFF; out_ready = 8'hFF;
    do_reset();
    in_valid = 1;
    while (m_cnt != 65535 && guard < 70000) begin
      in_data = 8'(guard);
      cycle();
      guard++;
      if (dq_ch.size() > 16) begin
        dq_ch.delete(); dq_data.delete();
      end
    end
    checks++;
    if (xfer_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload: got %h required ffff (loops %0d)", xfer_cnt, guard);
    end
    in_data = 8'hEE;
    cycle();
    checks++;
    if (xfer_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_to_zero: got %h required 0000", xfer_cnt);
    end
    in_valid = 0; out_ready = 8'h00;
    cycle();
    checks++;
    if (out_valid === 8'h00) begin
      failures++;
      $display("FAIL wrap_held_before_rst: valid=%h required one-hot", out_valid);
    end
    rst = 1;
    cycle();
    rst = 0;
    dq_ch.delete(); dq_data.delete();
    checks++;
    if (out_valid !== 8'h00 || sel !== 3'd0 || xfer_cnt !== 16'd0 || dut.ptr !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid: valid=%h sel=%0d cnt=%0d ptr=%0d required 00/0/0/0",
               out_valid, sel, xfer_cnt, dut.ptr);
    end
    out_ready = 8'hFF; in_valid = 1; in_data = 8'h77;
    cycle();
    in_valid = 0;
    cycle();
    checks++;
    if (dq_ch.size() != 1 || dq_ch[0] != 0 || dq_data[0] !== 8'h77 || xfer_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rst_dropped_word: deliveries=%0d cnt=%0d required only ch0 data 77, cnt 1",
               dq_ch.size(), xfer_cnt);
    end
  endtask

  initial begin
    m_full = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = 0;
    #2;
    test_reset();
    test_rotation();
    test_sparse();
    test_back_pressure();
    test_mask_change();
    test_random();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
